// File: rtl/rx_frame_if.sv
// Bit-sample / frame-result bundle between the RX oversampler, rx_frame_check and the RX FIFO side.
// master = sampler/consumer side, slave = the frame checker.
interface rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  // bit_valid is a one-cycle strobe with no back-pressure: the checker has no ready and must take
  // bit_in on every cycle bit_valid is high; frame_valid is likewise a one-cycle unacknowledged pulse.
  logic                  bit_valid;
  logic                  bit_in;
  logic                  par_en;
  logic                  par_type;
  logic [DATA_WIDTH-1:0] frame_data;
  logic                  frame_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  busy;
  logic [1:0]            fsm_state;

  modport master (
    output bit_valid, bit_in, par_en, par_type,
    input  frame_data, frame_valid, parity_error, stop_error, busy, fsm_state
  );

  modport slave (
    input  bit_valid, bit_in, par_en, par_type,
    output frame_data, frame_valid, parity_error, stop_error, busy, fsm_state
  );
endinterface

// File: rtl/rx_frame_check.sv
// UART RX frame checker: start, DATA_WIDTH data bits (LSB first), optional parity, STOP_BITS stops.
// Define RX_ERR_CNT_EN to add saturating parity/stop error counters with clr_cnt.
module rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  rx_frame_if.slave            rx
`ifdef RX_ERR_CNT_EN
  ,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stop_err_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_type_q, par_type_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop_acc_q, stop_acc_d;
  logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      stop_cnt_q     <= 1'b0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      par_bit_q      <= 1'b0;
      stop_acc_q     <= 1'b0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_type_q     <= par_type_d;
      par_bit_q      <= par_bit_d;
      stop_acc_q     <= stop_acc_d;
      frame_data_q   <= frame_data_d;
      frame_valid_q  <= frame_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_type_d     = par_type_q;
    par_bit_d      = par_bit_q;
    stop_acc_d     = stop_acc_q;
    frame_data_d   = frame_data_q;
    frame_valid_d  = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    if (rx.bit_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx.bit_in) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            stop_acc_d = 1'b0;
            par_en_d   = rx.par_en;
            par_type_d = rx.par_type;
          end
        end
        S_DATA: begin
          shift_d   = {rx.bit_in, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_DATA) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_bit_d = rx.bit_in;
          state_d   = S_STOP;
        end
        S_STOP: begin
          // A bad early stop bit is only accumulated; the frame always runs its full length.
          if (stop_cnt_q == LAST_STOP) begin
            state_d        = S_IDLE;
            frame_valid_d  = 1'b1;
            frame_data_d   = shift_q;
            parity_error_d = par_en_q & ((^{shift_q, par_bit_q}) != par_type_q);
            stop_error_d   = stop_acc_q | ~rx.bit_in;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            stop_acc_d = stop_acc_q | ~rx.bit_in;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx.frame_data   = frame_data_q;
  assign rx.frame_valid  = frame_valid_q;
  assign rx.parity_error = parity_error_q;
  assign rx.stop_error   = stop_error_q;
  assign rx.busy         = (state_q != S_IDLE);
  assign rx.fsm_state    = state_q;

`ifdef RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0] stop_cnt_err_q, stop_cnt_err_d;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      par_cnt_q      <= '0;
      stop_cnt_err_q <= '0;
    end else begin
      par_cnt_q      <= par_cnt_d;
      stop_cnt_err_q <= stop_cnt_err_d;
    end
  end

  // Clear beats a coincident increment; counters stick at all-ones.
  always_comb begin
    par_cnt_d      = par_cnt_q;
    stop_cnt_err_d = stop_cnt_err_q;
    if (clr_cnt) begin
      par_cnt_d      = '0;
      stop_cnt_err_d = '0;
    end else if (frame_valid_q) begin
      if (parity_error_q && (par_cnt_q != '1)) par_cnt_d = par_cnt_q + 1'b1;
      if (stop_error_q && (stop_cnt_err_q != '1)) stop_cnt_err_d = stop_cnt_err_q + 1'b1;
    end
  end

  assign par_err_cnt  = par_cnt_q;
  assign stop_err_cnt = stop_cnt_err_q;
`endif

endmodule

// File: tb/tb_rx_frame_check.sv
// Directed bench for rx_frame_check: one 8N1/8x1 instance and one two-stop-bit instance.
// Counter checks are compiled in when RX_ERR_CNT_EN is defined (CNT_WIDTH = 2).
module tb_rx_frame_check;

  logic CLK;
  logic Reset;
  int   errors;
  int   checks;

  rx_frame_if #(.DATA_WIDTH(8)) rx1 ();
  rx_frame_if #(.DATA_WIDTH(8)) rx2 ();

`ifdef RX_ERR_CNT_EN
  logic       clr_cnt1, clr_cnt2;
  logic [1:0] par_cnt1, stop_cnt1, par_cnt2, stop_cnt2;
`endif

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) dut1 (
    .CLK   (CLK),
    .Reset (Reset),
    .rx    (rx1)
`ifdef RX_ERR_CNT_EN
    ,
    .clr_cnt      (clr_cnt1),
    .par_err_cnt  (par_cnt1),
    .stop_err_cnt (stop_cnt1)
`endif
  );

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut2 (
    .CLK   (CLK),
    .Reset (Reset),
    .rx    (rx2)
`ifdef RX_ERR_CNT_EN
    ,
    .clr_cnt      (clr_cnt2),
    .par_err_cnt  (par_cnt2),
    .stop_err_cnt (stop_cnt2)
`endif
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Observed frames {parity_error, stop_error, data}; error flags outside a pulse are recorded.
  logic [9:0] got1_q[$];
  logic [9:0] got2_q[$];
  logic       leak1, leak2;

  always @(negedge CLK) begin
    if (rx1.frame_valid) got1_q.push_back({rx1.parity_error, rx1.stop_error, rx1.frame_data});
    else if (rx1.parity_error || rx1.stop_error) leak1 = 1'b1;
    if (rx2.frame_valid) got2_q.push_back({rx2.parity_error, rx2.stop_error, rx2.frame_data});
    else if (rx2.parity_error || rx2.stop_error) leak2 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input int which, input string tag, input logic [9:0] exp);
    logic [9:0] got;
    int         n;
    n = (which == 1) ? got1_q.size() : got2_q.size();
    if (n == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      got = (which == 1) ? got1_q.pop_front() : got2_q.pop_front();
      check(tag, {22'd0, got}, {22'd0, exp});
    end
  endtask

  // Driver: caller is positioned at a negedge; one bit_valid cycle per call.
  task automatic drive_bit(input int which, input logic b, input int gap);
    if (which == 1) begin rx1.bit_valid = 1'b1; rx1.bit_in = b; end
    else            begin rx2.bit_valid = 1'b1; rx2.bit_in = b; end
    @(negedge CLK);
    rx1.bit_valid = 1'b0; rx1.bit_in = 1'b1;
    rx2.bit_valid = 1'b0; rx2.bit_in = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Start bit, eight data bits and (optionally) the parity bit; stop bits are driven by the caller.
  task automatic send_head(input int which, input logic [7:0] data, input logic pe,
                           input logic pt, input logic pbit, input int gap);
    if (which == 1) begin rx1.par_en = pe; rx1.par_type = pt; end
    else            begin rx2.par_en = pe; rx2.par_type = pt; end
    drive_bit(which, 1'b0, gap);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i], gap);
    if (pe) drive_bit(which, pbit, gap);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    leak1  = 1'b0;
    leak2  = 1'b0;
    Reset  = 1'b0;
    rx1.bit_valid = 1'b0; rx1.bit_in = 1'b1; rx1.par_en = 1'b0; rx1.par_type = 1'b0;
    rx2.bit_valid = 1'b0; rx2.bit_in = 1'b1; rx2.par_en = 1'b0; rx2.par_type = 1'b0;
`ifdef RX_ERR_CNT_EN
    clr_cnt1 = 1'b0;
    clr_cnt2 = 1'b0;
`endif
    idle(3);
    check("rst_fv",    rx1.frame_valid, 0);
    check("rst_data",  rx1.frame_data, 0);
    check("rst_busy",  rx1.busy, 0);
    check("rst_perr",  rx1.parity_error, 0);
    check("rst_serr",  rx1.stop_error, 0);
    check("rst_state", rx1.fsm_state, 0);
    Reset = 1'b1;
    idle(2);

    // Idle-line ones do not start a frame
    drive_bit(1, 1'b1, 0);
    check("idle_busy", rx1.busy, 0);

    // 8N1 0x55
    drive_bit(1, 1'b0, 0);
    check("t1_busy", rx1.busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(1, (i % 2 == 0), 0);
    drive_bit(1, 1'b1, 0);
    check("t1_fv_pulse", rx1.frame_valid, 1);
    idle(2);
    check("t1_fv_drop", rx1.frame_valid, 0);
    check("t1_busy_end", rx1.busy, 0);
    check_frame(1, "t1_frame", {2'b00, 8'h55});

    // Even parity 0x07, parity bit 0 -> error; parity bit 1 -> clean (gapped strobes)
    send_head(1, 8'h07, 1'b1, 1'b0, 1'b0, 1);
    drive_bit(1, 1'b1, 2);
    check_frame(1, "t2_even_bad", {2'b10, 8'h07});
    send_head(1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
    drive_bit(1, 1'b1, 2);
    check_frame(1, "t2_even_ok", {2'b00, 8'h07});

    // par_en raised mid-frame is ignored: frame closes as 8N1
    rx1.par_en = 1'b0;
    drive_bit(1, 1'b0, 0);
    rx1.par_en = 1'b1;
    for (int i = 0; i < 8; i++) drive_bit(1, (i == 0) || (i == 7), 0);
    drive_bit(1, 1'b1, 2);
    check_frame(1, "t2_latch", {2'b00, 8'h81});
    check("t2_latch_idle", rx1.busy, 0);

    // Stop error 0xA3, then back-to-back clean 0x3C whose start coincides with the pulse
    send_head(1, 8'hA3, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(1, 1'b0, 0);
    send_head(1, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(1, 1'b1, 2);
    check_frame(1, "t3_stop_bad", {2'b01, 8'hA3});
    check_frame(1, "t3_b2b_ok",   {2'b00, 8'h3C});
    check("t3_data_hold", rx1.frame_data, 8'h3C);

    // Two stop bits, odd parity 0xFF, parity 1, stops 0,1
    send_head(2, 8'hFF, 1'b1, 1'b1, 1'b1, 0);
    drive_bit(2, 1'b0, 0);
    check("t4_no_early", rx2.frame_valid, 0);
    check("t4_busy_mid", rx2.busy, 1);
    drive_bit(2, 1'b1, 2);
    check_frame(2, "t4_frame", {2'b01, 8'hFF});

    // Reset after the fourth data bit abandons the frame
    rx1.par_en = 1'b0;
    drive_bit(1, 1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1, (i == 1), 0);
    Reset = 1'b0;
    idle(1);
    check("t5_rst_busy", rx1.busy, 0);
    check("t5_rst_data", rx1.frame_data, 0);
    Reset = 1'b1;
`ifdef RX_ERR_CNT_EN
    check("t5_cnt_clr", stop_cnt1, 0);
`endif
    send_head(1, 8'h12, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(1, 1'b1, 2);
    check("t5_one_pulse", got1_q.size(), 1);
    check_frame(1, "t5_frame", {2'b00, 8'h12});

`ifdef RX_ERR_CNT_EN
    // Saturating stop-error counter, then clear beating a coincident increment
    for (int f = 0; f < 5; f++) begin
      send_head(1, 8'h00, 1'b0, 1'b0, 1'b0, 0);
      drive_bit(1, 1'b0, 1);
      if (f == 1) check("t6_cnt2", stop_cnt1, 2);
    end
    idle(1);
    check("t6_sat", stop_cnt1, 3);
    check("t6_par_cnt", par_cnt1, 0);
    send_head(1, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    drive_bit(1, 1'b0, 0);
    clr_cnt1 = 1'b1;
    idle(1);
    clr_cnt1 = 1'b0;
    idle(1);
    check("t6_clr_wins", stop_cnt1, 0);
    got1_q.delete();
`endif

    idle(2);
    check("flag_leak1", leak1, 0);
    check("flag_leak2", leak2, 0);
    check("extra_frames1", got1_q.size(), 0);
    check("extra_frames2", got2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
